// File: rtl/fifo_pkt_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkt_pkg
// Shared definitions for the FIFO packet reader:
//   - state_e      : reader FSM encoding (IDLE / BURST)
//   - PKT_CNT_W    : width of the accepted-packet counter
//   - ENT_META_W   : number of side-band bits stored above the data word in
//                    each output buffer entry; layout is {pad, last, data}
//   - ent_pad_bit / ent_last_bit : bit positions of the side-band flags for a
//                    given data width
// -----------------------------------------------------------------------------
package fifo_pkt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int PKT_CNT_W  = 16;
  localparam int ENT_META_W = 2;

  function automatic int ent_pad_bit(input int width);
    return width + 1;
  endfunction

  function automatic int ent_last_bit(input int width);
    return width;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// -----------------------------------------------------------------------------
// stream_skid_buf
// Two-entry output buffer feeding a valid/ready stream. The head entry drives
// the stream directly from registers, so out_data_o never changes while
// out_valid_o=1 and out_ready_i=0.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (buffer emptied, entries zeroed)
//   wr_en_i      write one entry at the tail (only when room_o=1)
//   wr_data_i    entry to write
//   room_o       a write this cycle will be accepted
//   out_valid_o  head entry is valid
//   out_ready_i  downstream accepts the head entry
//   out_data_o   head entry
// -----------------------------------------------------------------------------
module stream_skid_buf #(
  parameter int DW = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          room_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic [DW-1:0] ent0_q;
  logic [DW-1:0] ent1_q;
  logic [1:0]    cnt_q;
  logic          pop;

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = ent0_q;
  assign pop         = out_valid_o & out_ready_i;
  // When full, the head is necessarily valid, so a pop frees a slot exactly
  // when the consumer is ready.
  assign room_o      = (cnt_q != 2'd2) | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({wr_en_i, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= wr_data_i;
          else               ent1_q <= wr_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q <= wr_data_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= wr_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// fifo_pkt_reader
// Read-side consumer of an async FIFO (first-word-fall-through port). Drains
// the FIFO in fixed PKT_LEN-word packets onto a valid/ready stream with a last
// marker. A packet starts only when the FIFO reports at least PKT_LEN words;
// if it runs dry mid-packet the reader stalls until more data arrives.
//
// Optional feature (macro FIFO_PKT_READER_FLUSH_EN): a residue smaller than a
// packet that sits in the FIFO for TIMEOUT idle cycles is flushed as a packet
// completed with PAD_WORD entries flagged by m_pad. Without the macro the
// residue waits indefinitely and m_pad stays 0.
//
// Ports:
//   r_clk, r_rst_n       clock, asynchronous active-low reset
//   fifo_dat             FIFO head word (valid when fifo_empty=0)
//   fifo_empty           FIFO empty flag
//   fifo_almost_empty    high when at least PKT_LEN words are available
//   fifo_rd_en           pop strobe (combinational from state, empty, ready)
//   m_valid/m_ready      stream handshake
//   m_data/m_last/m_pad  stream payload, end-of-packet, padding flag
//   busy                 a packet is in progress (until its last word leaves)
//   pkt_count            packets fully accepted downstream, wraps at 2^16
// -----------------------------------------------------------------------------
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               PKT_LEN  = 8,
  parameter int               TIMEOUT  = 64,
  parameter logic [WIDTH-1:0] PAD_WORD = '0
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic [WIDTH-1:0]     fifo_dat,
  input  logic                 fifo_empty,
  input  logic                 fifo_almost_empty,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic                 m_pad,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_count
);

`ifdef FIFO_PKT_READER_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  localparam int              CntW     = $clog2(PKT_LEN);
  localparam int              EntW     = WIDTH + ENT_META_W;
  localparam int              PadBit   = ent_pad_bit(WIDTH);
  localparam int              LastBit  = ent_last_bit(WIDTH);
  localparam logic [CntW-1:0] LastIdx  = CntW'(PKT_LEN - 1);
  localparam int              TimerW   = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerHit = TimerW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     word_cnt_q;
  logic                flush_q;
  logic                padding_q;
  logic [TimerW-1:0]   timer_q;
  logic [1:0]          pend_q, pend_d;
  logic                busy_q, busy_d;
  logic [PKT_CNT_W-1:0] pkt_count_q;

  logic            in_burst;
  logic            room;
  logic            pad_now;
  logic            wr_en;
  logic            wr_last;
  logic            pkt_done;
  logic            normal_start;
  logic            timer_run;
  logic            timer_hit;
  logic            start;
  logic            last_acc;
  logic [EntW-1:0] wr_entry;
  logic [EntW-1:0] head;

  assign in_burst = (state_q == BURST);

  // Once a flush burst has inserted a pad, every remaining word is a pad and
  // the FIFO is no longer popped, even if it refills in the meantime.
  assign pad_now    = FlushEn & in_burst & room & (padding_q | (flush_q & fifo_empty));
  assign fifo_rd_en = in_burst & room & ~fifo_empty & ~padding_q;
  assign wr_en      = fifo_rd_en | pad_now;
  assign wr_last    = (word_cnt_q == LastIdx);
  assign pkt_done   = wr_en & wr_last;
  assign wr_entry   = {pad_now, wr_last, (pad_now ? PAD_WORD : fifo_dat)};

  assign normal_start = ~fifo_empty & fifo_almost_empty;
  assign timer_run    = FlushEn & ~fifo_empty & ~fifo_almost_empty;
  assign timer_hit    = timer_run & (timer_q == TimerHit);
  assign start        = ~in_burst & (normal_start | timer_hit);

  assign last_acc = m_valid & m_ready & m_last;

  // pend counts completed packets whose last word is still buffered, so busy
  // stays high until the final word has actually been accepted downstream.
  assign pend_d = pend_q + {1'b0, pkt_done} - {1'b0, last_acc};

  always_comb begin
    state_d = state_q;
    if (start)                    state_d = BURST;
    else if (in_burst && pkt_done) state_d = IDLE;
  end

  assign busy_d = (state_d == BURST) | (pend_d != 2'd0);

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      flush_q     <= 1'b0;
      padding_q   <= 1'b0;
      timer_q     <= '0;
      pend_q      <= 2'd0;
      busy_q      <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;

      if (last_acc) pkt_count_q <= pkt_count_q + PKT_CNT_W'(1);

      if (pkt_done)   word_cnt_q <= '0;
      else if (wr_en) word_cnt_q <= word_cnt_q + CntW'(1);

      // A threshold start takes priority, so flush is only set by the timer.
      if (start)         flush_q <= timer_hit;
      else if (pkt_done) flush_q <= 1'b0;

      if (pkt_done)     padding_q <= 1'b0;
      else if (pad_now) padding_q <= 1'b1;

      if (in_burst || start || !timer_run) timer_q <= '0;
      else                                 timer_q <= timer_q + TimerW'(1);
    end
  end

  stream_skid_buf #(
    .DW(EntW)
  ) u_skid (
    .clk_i      (r_clk),
    .rst_ni     (r_rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_entry),
    .room_o     (room),
    .out_valid_o(m_valid),
    .out_ready_i(m_ready),
    .out_data_o (head)
  );

  assign m_data    = head[WIDTH-1:0];
  assign m_last    = head[LastBit];
  assign m_pad     = head[PadBit];
  assign busy      = busy_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_pkt_reader
// Bench for fifo_pkt_reader with a behavioural FWFT FIFO model and a stream
// scoreboard. Flush scenario is exercised when FIFO_PKT_READER_FLUSH_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_fifo_pkt_reader;

  localparam int             W    = 4;
  localparam int             PL   = 8;
  localparam int             TO   = 64;
  localparam int             AE   = 8;
  localparam logic [W-1:0]   PADW = 4'hA;

  logic          r_clk = 1'b0;
  logic          r_rst_n;
  logic [W-1:0]  fifo_dat;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          m_pad;
  logic          busy;
  logic [15:0]   pkt_count;

  always #5 r_clk = ~r_clk;

  fifo_pkt_reader #(
    .WIDTH   (W),
    .PKT_LEN (PL),
    .TIMEOUT (TO),
    .PAD_WORD(PADW)
  ) dut (
    .r_clk            (r_clk),
    .r_rst_n          (r_rst_n),
    .fifo_dat         (fifo_dat),
    .fifo_empty       (fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_rd_en       (fifo_rd_en),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last),
    .m_pad            (m_pad),
    .busy             (busy),
    .pkt_count        (pkt_count)
  );

  logic [W-1:0]   fifo_q[$];
  logic [W+1:0]   exp_q[$];     // {pad, last, data}
  int             pop_cyc[$];
  int             exp_idx;
  int             checks;
  int             errors;
  int             cyc;
  int             pop_total;
  int             acc_real;
  int             pkt_model;
  bit             ae_force;     // writer stopped after the flag was raised
  bit             hold_chk;
  logic [W+2:0]   held;

  task automatic refresh();
    fifo_empty        = (fifo_q.size() == 0);
    fifo_dat          = fifo_empty ? '0 : fifo_q[0];
    fifo_almost_empty = ae_force || (fifo_q.size() >= AE);
  endtask

  task automatic push_word(input logic [W-1:0] d);
    logic lst;
    lst = ((exp_idx % PL) == PL - 1);
    fifo_q.push_back(d);
    exp_q.push_back({1'b0, lst, d});
    exp_idx++;
    refresh();
  endtask

  task automatic push_pad_expect();
    logic lst;
    lst = ((exp_idx % PL) == PL - 1);
    exp_q.push_back({1'b1, lst, PADW});
    exp_idx++;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #2;
  endtask

  // FIFO model: pop on the edge where fifo_rd_en is high, update flags after.
  always @(posedge r_clk) begin
    cyc = cyc + 1;
    if (r_rst_n && fifo_rd_en) begin
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow rd_en=1 with empty FIFO at cycle %0d", cyc);
      end else begin
        void'(fifo_q.pop_front());
        pop_total++;
        pop_cyc.push_back(cyc);
      end
    end
    #1 refresh();
  end

  // Stream monitor: scoreboard, hold-stability and full-buffer checks.
  always @(negedge r_clk) begin
    logic [W+1:0] e;
    if (r_rst_n) begin
      if (hold_chk) begin
        checks++;
        if ({m_valid, m_pad, m_last, m_data} !== held) begin
          errors++;
          $display("FAIL hold_stable got %h required %h", {m_valid, m_pad, m_last, m_data}, held);
        end
      end
      if (!m_ready && (pop_total - acc_real) >= 2) begin
        checks++;
        if (fifo_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL rd_en_when_full got %b required 0", fifo_rd_en);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_word got pad=%0b last=%0b data=%h required no word", m_pad, m_last, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_pad, m_last, m_data} !== e) begin
            errors++;
            $display("FAIL stream_word got pad=%0b last=%0b data=%h required pad=%0b last=%0b data=%h",
                     m_pad, m_last, m_data, e[W+1], e[W], e[W-1:0]);
          end
          if (!e[W+1]) acc_real++;
          if (e[W])    pkt_model++;
        end
      end
      hold_chk = m_valid && !m_ready;
      held     = {m_valid, m_pad, m_last, m_data};
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || m_valid || exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      @(negedge r_clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout busy=%b exp_left=%0d fifo_left=%0d required idle", name, busy, exp_q.size(), fifo_q.size());
    end
  endtask

  task automatic wait_rd_en(input int budget, input string name);
    int n = 0;
    @(negedge r_clk);
    while (!fifo_rd_en && n < budget) begin
      @(negedge r_clk);
      n++;
    end
    checks++;
    if (!fifo_rd_en) begin
      errors++;
      $display("FAIL %s_no_pop rd_en=%b required 1 within %0d cycles", name, fifo_rd_en, budget);
    end
  endtask

  task automatic check_pkt_count(input logic [15:0] req, input string name);
    checks++;
    if (pkt_count !== req) begin
      errors++;
      $display("FAIL %s pkt_count=%0d required %0d", name, pkt_count, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({fifo_rd_en, m_valid, m_last, m_pad, busy} !== 5'b0) begin
      errors++;
      $display("FAIL %s_flags rd_en=%b valid=%b last=%b pad=%b busy=%b required all 0",
               name, fifo_rd_en, m_valid, m_last, m_pad, busy);
    end
    checks++;
    if (m_data !== '0) begin
      errors++;
      $display("FAIL %s_data m_data=%h required 0", name, m_data);
    end
    check_pkt_count(16'd0, {name, "_count"});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge r_clk);
    check_reset_outputs("reset");
    tick();
    r_rst_n = 1'b1;
    @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release valid=%b busy=%b required 0 0", m_valid, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_packet();
    pop_cyc = {};
    tick();
    for (int i = 0; i < PL; i++) push_word(W'(i * 3 + 1));
    wait_rd_en(10, "single");
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_pop m_valid=%b required 0", m_valid);
    end
    @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency m_valid=%b required 1 one cycle after first pop", m_valid);
    end
    wait_idle(100, "single");
    checks++;
    if (pop_cyc.size() != PL) begin
      errors++;
      $display("FAIL single_pops got %0d required %0d", pop_cyc.size(), PL);
    end else begin
      for (int i = 1; i < PL; i++) begin
        checks++;
        if (pop_cyc[i] - pop_cyc[i-1] != 1) begin
          errors++;
          $display("FAIL single_gap idx=%0d gap=%0d required 1", i, pop_cyc[i] - pop_cyc[i-1]);
        end
      end
    end
    check_pkt_count(16'd1, "single_count");
    $display("test_single_packet done pkt_count=%0d", pkt_count);
  endtask

  task automatic test_back_to_back();
    pop_cyc = {};
    tick();
    for (int i = 0; i < 2 * PL; i++) push_word(W'(15 - (i % 16)));
    wait_idle(200, "b2b");
    checks++;
    if (pop_cyc.size() != 2 * PL) begin
      errors++;
      $display("FAIL b2b_pops got %0d required %0d", pop_cyc.size(), 2 * PL);
    end else begin
      for (int i = 1; i < 2 * PL; i++) begin
        checks++;
        if (pop_cyc[i] - pop_cyc[i-1] != ((i == PL) ? 2 : 1)) begin
          errors++;
          $display("FAIL b2b_gap idx=%0d gap=%0d required %0d", i, pop_cyc[i] - pop_cyc[i-1], (i == PL) ? 2 : 1);
        end
      end
    end
    check_pkt_count(16'd3, "b2b_count");
    $display("test_back_to_back done pkt_count=%0d", pkt_count);
  endtask

  task automatic test_ready_toggle();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    tick();
    for (int i = 0; i < PL; i++) push_word(W'($urandom_range(0, 15)));
    while ((busy || exp_q.size() != 0 || fifo_q.size() != 0) && k < 200) begin
      m_ready = pat[k % 4];
      tick();
      k++;
    end
    m_ready = 1'b1;
    wait_idle(50, "toggle");
    check_pkt_count(16'(pkt_model), "toggle_count");
    $display("test_ready_toggle done pkt_count=%0d", pkt_count);
  endtask

  task automatic test_stall();
    int n = 0;
    ae_force = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push_word(W'(i + 8));
    wait_rd_en(10, "stall");
    ae_force = 1'b0;
    refresh();
    while (fifo_q.size() != 0 && n < 50) begin
      @(negedge r_clk);
      n++;
    end
    repeat (3) @(negedge r_clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge r_clk);
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b busy=%b rd_en=%b required 0 1 0", i, m_valid, busy, fifo_rd_en);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) push_word(W'(i + 13));
    wait_idle(50, "stall");
    check_pkt_count(16'd5, "stall_count");
    $display("test_stall done pkt_count=%0d", pkt_count);
  endtask

`ifdef FIFO_PKT_READER_FLUSH_EN
  task automatic test_flush();
    int c0;
    pop_cyc = {};
    tick();
    c0 = cyc;
    for (int i = 0; i < 3; i++) push_word(W'(i + 2));
    for (int i = 0; i < PL - 3; i++) push_pad_expect();
    wait_idle(TO + 50, "flush");
    checks++;
    if (pop_cyc.size() != 3) begin
      errors++;
      $display("FAIL flush_pops got %0d required 3", pop_cyc.size());
    end else begin
      checks++;
      if (pop_cyc[0] - c0 != TO + 1) begin
        errors++;
        $display("FAIL flush_start first pop after %0d cycles required %0d", pop_cyc[0] - c0, TO + 1);
      end
    end
    check_pkt_count(16'd6, "flush_count");
    $display("test_flush done pkt_count=%0d", pkt_count);
  endtask
`endif

  task automatic test_reset_mid();
    int a0;
    int n = 0;
    a0 = acc_real;
    tick();
    for (int i = 0; i < PL; i++) push_word(W'(i ^ 5));
    @(negedge r_clk);
    #1;
    while (acc_real < a0 + 4 && n < 50) begin
      @(negedge r_clk);
      #1;
      n++;
    end
    @(posedge r_clk);
    #3;
    r_rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    // Buffered words are lost; what is still in the FIFO starts a new packet.
    exp_q     = {};
    exp_idx   = 0;
    pkt_model = 0;
    pop_total = acc_real;
    for (int i = 0; i < fifo_q.size(); i++) begin
      exp_q.push_back({1'b0, ((exp_idx % PL) == PL - 1), fifo_q[i]});
      exp_idx++;
    end
    tick();
    r_rst_n = 1'b1;
    while (fifo_q.size() < PL) push_word(W'($urandom_range(0, 15)));
    wait_idle(100, "reset_mid");
    check_pkt_count(16'd1, "reset_mid_count");
    $display("test_reset_mid done pkt_count=%0d", pkt_count);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    exp_idx   = 0;
    pop_total = 0;
    acc_real  = 0;
    pkt_model = 0;
    ae_force  = 1'b0;
    hold_chk  = 1'b0;
    held      = '0;
    r_rst_n   = 1'b0;
    m_ready   = 1'b1;
    refresh();

    test_reset();
    test_single_packet();
    test_back_to_back();
    test_ready_toggle();
    test_stall();
`ifdef FIFO_PKT_READER_FLUSH_EN
    test_flush();
`endif
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_words got %0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
